// File: rtl/aes_text_out_serializer_pkg.sv
// Shared types and helpers for the AES text_out serializer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_out_pkg;

    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 2;
    localparam int NW     = DATA_W / WORD_W;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    typedef logic [DATA_W-1:0] block_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  widx_t;

    // Word idx of a block, most-significant word first.
    function automatic word_t word_sel(input block_t block, input widx_t idx);
        return block[DATA_W-1 - int'(idx)*WORD_W -: WORD_W];
    endfunction

endpackage

// File: rtl/aes_text_out_serializer_if.sv
// Word stream from the serializer toward the bus/DMA sink (optional AES_TEXT_OUT_PARITY_EN adds out_par).
// Latency: n/a (wires only).
// Backpressure: sink holds out_ready low to stall; source keeps data stable while stalled.
interface aes_text_out_serializer_if #(
    parameter int WORD_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
`ifdef AES_TEXT_OUT_PARITY_EN
    logic [WORD_W/8-1:0] out_par;
`endif

    modport master (
        output out_valid,
        output out_data,
        output out_last,
`ifdef AES_TEXT_OUT_PARITY_EN
        output out_par,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
`ifdef AES_TEXT_OUT_PARITY_EN
        input  out_par,
`endif
        output out_ready
    );

endinterface

// File: rtl/aes_text_out_serializer_block_buf.sv
// DEPTH-entry block FIFO with level count; push while full succeeds only when a pop happens in the same cycle.
// Latency: pushed block is visible at the head one cycle after the push.
// Backpressure: rejects pushes when full and not popping (o_push_ok low).
module aes_out_block_buf #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_dat,
    output logic [LVL_W-1:0]  o_level,
    output logic [LVL_W-1:0]  o_level_nxt,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_push_ok
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_pop_ok;

    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign w_pop_ok   = i_pop && !o_empty;
    // When full, the slot being freed by the pop is the write slot, so the
    // incoming block lands there while the old head is still read this cycle.
    assign o_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rptr];

    // Next occupancy, net of simultaneous push and pop.
    always_comb begin
        o_level_nxt = r_level;
        case ({o_push_ok, w_pop_ok})
            2'b10:   o_level_nxt = r_level + LVL_W'(1);
            2'b01:   o_level_nxt = r_level - LVL_W'(1);
            default: o_level_nxt = r_level;
        endcase
    end

    // Pointer and level state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (o_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            r_level <= o_level_nxt;
        end
    end

    // Block storage; contents need no reset because level gates all reads.
    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wptr] <= i_push_dat;
    end

endmodule

// File: rtl/aes_text_out_serializer.sv
// Captures AES text_out on done, buffers DEPTH blocks, streams MSW-first words (AES_TEXT_OUT_PARITY_EN adds out_par).
// Latency: done in cycle t with empty buffer gives out_valid in cycle t+1; one word per cycle, no inter-block bubble.
// Backpressure: out_ready stalls the stream with stable outputs; a done while full is dropped and sets sticky overflow.
module aes_text_out_serializer #(
    parameter int DATA_W = aes_out_pkg::DATA_W,
    parameter int WORD_W = aes_out_pkg::WORD_W,
    parameter int DEPTH  = aes_out_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [DATA_W-1:0]        text_out,
    aes_text_out_serializer_if.master out_if,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_ovf
);
    import aes_out_pkg::*;

    // Package widths (block_t, word_t, word_sel) must match DATA_W/WORD_W here.
`ifdef AES_TEXT_OUT_PARITY_EN
    localparam int PAR_W  = DATA_W / 8;
`else
    localparam int PAR_W  = 0;
`endif
    localparam int STORE_W = DATA_W + PAR_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_SEND = 1'(SEND);

    logic [0:0]         r_state;
    widx_t              r_widx;
    logic               r_ovf;

    logic [STORE_W-1:0] w_push_dat;
    logic [STORE_W-1:0] w_head_dat;
    logic [DATA_W-1:0]  w_head_blk;
    logic [LVL_W-1:0]   w_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_valid;
    logic               w_hs;
    logic               w_last_word;
    logic               w_pop;

`ifdef AES_TEXT_OUT_PARITY_EN
    localparam int WPAR_W = WORD_W / 8;
    logic [PAR_W-1:0]   w_cap_par;
    logic [PAR_W-1:0]   w_head_par;

    // Even-parity bit per byte of the captured block, stored with it.
    always_comb begin
        w_cap_par = '0;
        for (int i = 0; i < PAR_W; i++) begin
            w_cap_par[i] = ^text_out[8*i +: 8];
        end
    end

    assign w_push_dat = {text_out, w_cap_par};
    assign w_head_par = w_head_dat[PAR_W-1:0];
    assign out_if.out_par = w_valid ? w_head_par[PAR_W-1 - int'(r_widx)*WPAR_W -: WPAR_W] : '0;
`else
    assign w_push_dat = text_out;
`endif

    assign w_head_blk = w_head_dat[STORE_W-1 -: DATA_W];

    aes_out_block_buf #(
        .DATA_W (STORE_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (done),
        .i_push_dat  (w_push_dat),
        .i_pop       (w_pop),
        .o_head_dat  (w_head_dat),
        .o_level     (w_level),
        .o_level_nxt (w_level_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_push_ok   (w_push_ok)
    );

    assign w_valid     = (r_state == ST_SEND) && !w_empty;
    assign w_hs        = w_valid && out_if.out_ready;
    assign w_last_word = (r_widx == IDX_W'(NW - 1));
    assign w_pop       = w_hs && w_last_word;

    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_valid ? word_sel(w_head_blk, r_widx) : '0;
    assign out_if.out_last  = w_valid && w_last_word;
    assign overflow         = r_ovf;
    assign level            = w_level;

    // FSM: SEND whenever a block will be held next cycle, so a capture raises valid one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= (w_level_nxt != '0) ? ST_SEND : ST_IDLE;
        end
    end

    // Word index advances on each accepted word and wraps after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_widx <= '0;
        end else if (w_hs) begin
            r_widx <= w_last_word ? '0 : r_widx + IDX_W'(1);
        end
    end

    // Sticky overflow: a dropped block beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (done && w_full && !w_push_ok) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_text_out_serializer.sv
// Scoreboard bench for aes_text_out_serializer: directed blocks, queue of expected words, negedge monitor.
// Latency: checks first-word timing and no-bubble streaming explicitly.
// Backpressure: toggles out_ready and checks output stability while stalled.
module tb_aes_text_out_serializer;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [3:0]  p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         done;
    logic [127:0] text_out;
    logic         overflow;
    logic [1:0]   level;
    logic         clr_ovf;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    logic         prev_stall = 1'b0;
    logic [31:0]  prev_d;
    logic         prev_l;
    exp_t         e;

    always #5 clk = ~clk;

    aes_text_out_serializer_if #(.WORD_W(32)) u_if ();

    aes_text_out_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .done     (done),
        .text_out (text_out),
        .out_if   (u_if),
        .overflow (overflow),
        .level    (level),
        .clr_ovf  (clr_ovf)
    );

    function automatic logic [3:0] par_of(input logic [31:0] w);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic last);
        exp_t x;
        x.d = w;
        x.l = last;
        x.p = par_of(w);
        q.push_back(x);
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < 4; i++) push_word(b[127-32*i -: 32], (i == 3));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [127:0] b);
        done     = 1'b1;
        text_out = b;
        tick();
        done     = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int c;
        c = 0;
        while (q.size() != 0 && c < maxc) begin
            tick();
            c++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d words still expected after %0d cycles, required 0", name, q.size(), maxc);
            q.delete();
        end
    endtask

    // Monitor: compare every accepted word against the queue, and check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", u_if.out_valid, 1);
                check("stall_data", u_if.out_data, prev_d);
                check("stall_last", u_if.out_last, prev_l);
            end
            if (!u_if.out_valid) check("idle_last", u_if.out_last, 0);
            if (u_if.out_valid && u_if.out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, required no word", u_if.out_data);
                end else begin
                    e = q.pop_front();
                    check("word_data", u_if.out_data, e.d);
                    check("word_last", u_if.out_last, e.l);
`ifdef AES_TEXT_OUT_PARITY_EN
                    check("word_par", u_if.out_par, e.p);
`endif
                end
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_d     = u_if.out_data;
            prev_l     = u_if.out_last;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
        $fatal(1);
    end

    initial begin
        logic [127:0] blk1, blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g, blk_h;
        logic [3:0]   pat;
        blk1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        blk_a = 128'h00112233445566778899aabbccddeeff;
        blk_b = 128'hdeadbeefcafef00d0123456789abcdef;
        blk_c = 128'hffffffff00000000ffffffff00000000;
        blk_d = 128'h3243f6a8885a308d313198a2e0370734;
        blk_e = 128'h11111111222222223333333344444444;
        blk_f = 128'h55555555666666667777777788888888;
        blk_g = 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f;
        blk_h = 128'h0badc0de1badb0022bad10053bad2007;
        pat   = 4'b1001;

        rst = 1'b1; done = 1'b0; clr_ovf = 1'b0; text_out = '0; u_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", u_if.out_valid, 0);
        check("rst_last", u_if.out_last, 0);
        check("rst_data", u_if.out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", level, 0);
`ifdef AES_TEXT_OUT_PARITY_EN
        check("rst_par", u_if.out_par, 0);
`endif
        tick();

        // 1: single block, one word per cycle starting the cycle after done
        u_if.out_ready = 1'b1;
        push_word(32'h69c4e0d8, 1'b0);
        push_word(32'h6a7b0430, 1'b0);
        push_word(32'hd8cdb780, 1'b0);
        push_word(32'h70b4c55a, 1'b1);
        pulse_done(blk1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_valid_each_cycle", u_if.out_valid, 1);
        end
        @(negedge clk);
        check("t1_valid_after", u_if.out_valid, 0);
        check("t1_level_after", level, 0);
        check("t1_words_left", q.size(), 0);
        tick();

        // 2: back-pressure with ready pattern 1,0,0,1
        u_if.out_ready = 1'b0;
        push_block(blk1);
        pulse_done(blk1);
        for (int i = 0; i < 16; i++) begin
            u_if.out_ready = pat[i % 4];
            tick();
        end
        u_if.out_ready = 1'b1;
        drain("t2_drain", 20);
        @(negedge clk);
        check("t2_level", level, 0);
        tick();

        // 3: overflow with three blocks while stalled; C is dropped
        u_if.out_ready = 1'b0;
        push_block(blk_a);
        push_block(blk_b);
        pulse_done(blk_a);
        pulse_done(blk_b);
        pulse_done(blk_c);
        @(negedge clk);
        check("t3_level_full", level, 2);
        check("t3_ovf_set", overflow, 1);
        tick();
        done = 1'b1; clr_ovf = 1'b1; text_out = blk_c;
        tick();
        done = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        check("t3_ovf_beats_clr", overflow, 1);
        check("t3_level_still_full", level, 2);
        tick();
        u_if.out_ready = 1'b1;
        drain("t3_drain", 40);
        @(negedge clk);
        check("t3_level_empty", level, 0);
        check("t3_ovf_sticky", overflow, 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("t3_ovf_cleared", overflow, 0);
        tick();

        // 4: push at full while the head block's last word is accepted
        u_if.out_ready = 1'b0;
        push_block(blk_e);
        push_block(blk_f);
        push_block(blk_d);
        pulse_done(blk_e);
        pulse_done(blk_f);
        u_if.out_ready = 1'b1;
        tick();
        tick();
        tick();
        done = 1'b1; text_out = blk_d;
        tick();
        done = 1'b0;
        u_if.out_ready = 1'b0;
        @(negedge clk);
        check("t4_level_kept", level, 2);
        check("t4_no_ovf", overflow, 0);
        tick();
        u_if.out_ready = 1'b1;
        drain("t4_drain", 40);
        @(negedge clk);
        check("t4_level_empty", level, 0);
        tick();

        // 5: reset after two words of a block; next block starts at word 0
        u_if.out_ready = 1'b1;
        push_word(32'ha5a5a5a5, 1'b0);
        push_word(32'h5a5a5a5a, 1'b0);
        pulse_done(blk_g);
        tick();
        tick();
        rst = 1'b1;
        u_if.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after_rst", u_if.out_valid, 0);
        check("t5_level_after_rst", level, 0);
        check("t5_data_after_rst", u_if.out_data, 0);
        check("t5_partial_words_left", q.size(), 0);
        tick();
        u_if.out_ready = 1'b1;
        push_block(blk_h);
        pulse_done(blk_h);
        @(negedge clk);
        check("t5_first_word", u_if.out_data, 32'h0badc0de);
        tick();
        drain("t5_drain", 20);
        @(negedge clk);
        check("t5_level_empty", level, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
